// File: rtl/ship_board_pkg.sv
// ship_board_pkg: shared cell/message types and board geometry for the own-fleet board
package ship_board_pkg;

    localparam int GRID_N    = 10;
    localparam int MAX_SHIPS = 11;
    localparam int CELLS     = GRID_N * GRID_N;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_SHIP  = 2'b01,
        CELL_HIT   = 2'b10,
        CELL_MISS  = 2'b11
    } cell_t;

    localparam logic [1:0] MSG_MISS = 2'b01;
    localparam logic [1:0] MSG_HIT  = 2'b10;
    localparam logic [1:0] MSG_SUNK = 2'b11;

    // both nibbles of a {row, col} address must name a cell on the board
    function automatic logic in_range(input logic [7:0] a);
        return (a[7:4] < 4'(GRID_N)) && (a[3:0] < 4'(GRID_N));
    endfunction

    // linear cell index row*GRID_N + col
    function automatic logic [6:0] cell_idx(input logic [7:0] a);
        return {3'b000, a[7:4]} * 7'(GRID_N) + {3'b000, a[3:0]};
    endfunction

endpackage

// File: rtl/ship_board_if.sv
// ship_board_if: shot request / response handshake between link logic and the board
interface ship_board_if;

    logic       shot_valid;
    logic [7:0] shot_addr;
    logic       busy;
    logic       msg_valid;
    logic       msg_ready;
    logic [1:0] msg_out;
    logic       fleet_lost;

    modport master (
        output shot_valid, shot_addr, msg_ready,
        input  busy, msg_valid, msg_out, fleet_lost
    );

    modport slave (
        input  shot_valid, shot_addr, msg_ready,
        output busy, msg_valid, msg_out, fleet_lost
    );

endinterface

// File: rtl/ship_board_mem.sv
// ship_board_mem: 100x2-bit cell array, one write port, a combinational lookup port and a registered render port
module ship_board_mem
    import ship_board_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_we,
    input  logic [6:0] i_waddr,
    input  cell_t      i_wdata,
    input  logic [6:0] i_laddr,
    output cell_t      o_ldata,
    input  logic [6:0] i_raddr,
    input  logic       i_rvalid,
    output cell_t      o_rdata
);

    cell_t r_mem [CELLS];
    cell_t r_rdata;

    assign o_ldata = (i_laddr < 7'(CELLS)) ? r_mem[i_laddr] : CELL_EMPTY;
    assign o_rdata = r_rdata;

    // cell storage: clear wins over the single write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CELLS; i++) r_mem[i] <= CELL_EMPTY;
        end else if (i_clr) begin
            for (int i = 0; i < CELLS; i++) r_mem[i] <= CELL_EMPTY;
        end else if (i_we && (i_waddr < 7'(CELLS))) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // render port: registered read, returns the pre-write value on a write cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= CELL_EMPTY;
        end else begin
            r_rdata <= (i_clr || !i_rvalid || (i_raddr >= 7'(CELLS))) ? CELL_EMPTY : r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/ship_board.sv
// ship_board: own-fleet board store, ship placement and opponent shot resolution
module ship_board
    import ship_board_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_board_clr,
    input  logic       i_place_en,
    input  logic       i_pick_ship,
    input  logic [7:0] i_mouse_position,
    output logic [3:0] o_ship_count,
    input  logic [7:0] i_rd_addr,
    output logic [1:0] o_rd_cell,
    ship_board_if.slave shot
);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_RESPOND} state_t;

    state_t     r_state;
    logic [7:0] r_shot_addr;
    cell_t      r_cell;
    logic [3:0] r_hits;
    logic       r_busy;
    logic       r_msg_valid;
    logic [1:0] r_msg_out;
    logic       r_fleet_lost;
    logic       r_pick_d;
    logic       r_pending;
    logic [7:0] r_place_addr;
    logic [3:0] r_ship_count;

    cell_t      w_lcell;
    cell_t      w_rd_cell;
    cell_t      w_wdata;
    logic       w_pick_edge;
    logic       w_place_ok;
    logic       w_upd_write;
    logic       w_we;
    logic       w_sunk;
    logic [6:0] w_laddr;
    logic [6:0] w_waddr;
    logic [3:0] w_new_hits;

    // placement only ever uses the ports while the shot FSM is idle, so they never collide
    assign w_pick_edge = i_pick_ship && !r_pick_d && i_place_en;
    assign w_laddr     = (r_state == S_IDLE) ? cell_idx(r_place_addr) : cell_idx(r_shot_addr);
    assign w_place_ok  = (r_state == S_IDLE) && !shot.shot_valid && r_pending && in_range(r_place_addr)
                         && (w_lcell == CELL_EMPTY) && (r_ship_count < 4'(MAX_SHIPS));
    assign w_upd_write = (r_state == S_UPDATE) && ((r_cell == CELL_SHIP) || (r_cell == CELL_EMPTY));
    assign w_we        = w_place_ok || w_upd_write;
    assign w_waddr     = w_upd_write ? cell_idx(r_shot_addr) : cell_idx(r_place_addr);
    assign w_wdata     = !w_upd_write ? CELL_SHIP : (r_cell == CELL_SHIP) ? CELL_HIT : CELL_MISS;
    assign w_new_hits  = r_hits + 4'd1;
    assign w_sunk      = (w_new_hits == r_ship_count) && (r_ship_count != 4'd0);

    assign o_ship_count    = r_ship_count;
    assign o_rd_cell       = w_rd_cell;
    assign shot.busy       = r_busy;
    assign shot.msg_valid  = r_msg_valid;
    assign shot.msg_out    = r_msg_out;
    assign shot.fleet_lost = r_fleet_lost;

    ship_board_mem u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (i_board_clr),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_laddr  (w_laddr),
        .o_ldata  (w_lcell),
        .i_raddr  (cell_idx(i_rd_addr)),
        .i_rvalid (in_range(i_rd_addr)),
        .o_rdata  (w_rd_cell)
    );

    // placement: edge-detect pick_ship, hold one pending cell, commit it when the shot side is quiet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pick_d     <= 1'b0;
            r_pending    <= 1'b0;
            r_place_addr <= 8'h00;
            r_ship_count <= 4'd0;
        end else if (i_board_clr) begin
            r_pick_d     <= 1'b0;
            r_pending    <= 1'b0;
            r_place_addr <= 8'h00;
            r_ship_count <= 4'd0;
        end else begin
            r_pick_d <= i_pick_ship;
            if (w_place_ok) r_ship_count <= r_ship_count + 4'd1;
            if (w_pick_edge) begin
                r_place_addr <= i_mouse_position;
                r_pending    <= 1'b1;
            end else if ((r_state == S_IDLE) && !shot.shot_valid) begin
                r_pending    <= 1'b0;
            end
        end
    end

    // shot FSM: latch, read cell, update cell and build reply, hold reply until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_shot_addr  <= 8'h00;
            r_cell       <= CELL_EMPTY;
            r_hits       <= 4'd0;
            r_busy       <= 1'b0;
            r_msg_valid  <= 1'b0;
            r_msg_out    <= 2'b00;
            r_fleet_lost <= 1'b0;
        end else if (i_board_clr) begin
            r_state      <= S_IDLE;
            r_shot_addr  <= 8'h00;
            r_cell       <= CELL_EMPTY;
            r_hits       <= 4'd0;
            r_busy       <= 1'b0;
            r_msg_valid  <= 1'b0;
            r_msg_out    <= 2'b00;
            r_fleet_lost <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (shot.shot_valid) begin
                        r_shot_addr <= shot.shot_addr;
                        r_busy      <= 1'b1;
                        r_state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_cell  <= in_range(r_shot_addr) ? w_lcell : CELL_MISS;
                    r_state <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (r_cell == CELL_SHIP) begin
                        r_hits    <= w_new_hits;
                        r_msg_out <= w_sunk ? MSG_SUNK : MSG_HIT;
                        if (w_sunk) r_fleet_lost <= 1'b1;
                    end else begin
                        r_msg_out <= (r_cell == CELL_HIT) ? MSG_HIT : MSG_MISS;
                    end
                    r_msg_valid <= 1'b1;
                    r_state     <= S_RESPOND;
                end
                S_RESPOND: begin
                    if (shot.msg_ready) begin
                        r_msg_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ship_board.sv
// tb_ship_board: randomized self-checking bench for ship_board against a board-level model
module tb_ship_board;
    import ship_board_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       board_clr = 1'b0;
    logic       place_en = 1'b0;
    logic       pick_ship = 1'b0;
    logic [7:0] mouse_position = 8'h00;
    logic [7:0] rd_addr = 8'h00;
    logic [3:0] ship_count;
    logic [1:0] rd_cell;

    int checks = 0;
    int errors = 0;

    int grid [GRID_N][GRID_N];
    int m_ships;
    int m_hits;
    bit m_lost;

    ship_board_if bus();

    always #5 clk = ~clk;

    ship_board dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_board_clr      (board_clr),
        .i_place_en       (place_en),
        .i_pick_ship      (pick_ship),
        .i_mouse_position (mouse_position),
        .o_ship_count     (ship_count),
        .i_rd_addr        (rd_addr),
        .o_rd_cell        (rd_cell),
        .shot             (bus)
    );

    function automatic void model_clear();
        for (int r = 0; r < GRID_N; r++)
            for (int c = 0; c < GRID_N; c++) grid[r][c] = 0;
        m_ships = 0;
        m_hits  = 0;
        m_lost  = 0;
    endfunction

    function automatic void model_place(input logic [7:0] a, input bit en);
        int r = int'(a[7:4]);
        int c = int'(a[3:0]);
        if (en && r < GRID_N && c < GRID_N && m_ships < MAX_SHIPS && grid[r][c] == 0) begin
            grid[r][c] = 1;
            m_ships++;
        end
    endfunction

    function automatic logic [1:0] model_shot(input logic [7:0] a);
        int r = int'(a[7:4]);
        int c = int'(a[3:0]);
        if (r >= GRID_N || c >= GRID_N) return 2'b01;
        case (grid[r][c])
            0: begin grid[r][c] = 3; return 2'b01; end
            1: begin
                grid[r][c] = 2;
                m_hits++;
                if (m_hits == m_ships) begin m_lost = 1; return 2'b11; end
                return 2'b10;
            end
            2: return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    task automatic reset_dut();
        rst_n = 1'b0; board_clr = 1'b0; pick_ship = 1'b0; place_en = 1'b1;
        bus.shot_valid = 1'b0; bus.shot_addr = 8'h00; bus.msg_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_clear();
    endtask

    task automatic do_pick(input logic [7:0] a, input bit en);
        @(negedge clk);
        place_en = en; pick_ship = 1'b1; mouse_position = a;
        @(negedge clk);
        pick_ship = 1'b0;
        repeat (2) @(negedge clk);
        place_en = 1'b1;
        model_place(a, en);
    endtask

    task automatic do_shot(input logic [7:0] a, output logic [1:0] msg, output int lat);
        @(negedge clk);
        bus.shot_valid = 1'b1; bus.shot_addr = a;
        @(negedge clk);
        bus.shot_valid = 1'b0;
        lat = 1;
        while (!bus.msg_valid && lat < 20) begin @(negedge clk); lat++; end
        msg = bus.msg_out;
        bus.msg_ready = 1'b1;
        @(negedge clk);
        bus.msg_ready = 1'b0;
    endtask

    task automatic read_cell(input logic [7:0] a, output logic [1:0] v);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        v = rd_cell;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (ship_count !== 4'd0) begin errors++; $display("FAIL reset_ship_count: got %0d exp 0", ship_count); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
        checks++; if (bus.msg_valid !== 1'b0) begin errors++; $display("FAIL reset_msg_valid: got %b exp 0", bus.msg_valid); end
        checks++; if (bus.msg_out !== 2'b00) begin errors++; $display("FAIL reset_msg_out: got %b exp 00", bus.msg_out); end
        checks++; if (bus.fleet_lost !== 1'b0) begin errors++; $display("FAIL reset_fleet_lost: got %b exp 0", bus.fleet_lost); end
        checks++; if (rd_cell !== 2'b00) begin errors++; $display("FAIL reset_rd_cell: got %b exp 00", rd_cell); end
    endtask

    task automatic test_placement();
        logic [1:0] v;
        reset_dut();
        do_pick(8'h23, 1'b1);
        do_pick(8'h23, 1'b1);
        do_pick(8'hA0, 1'b1);
        do_pick(8'h45, 1'b0);
        checks++; if (ship_count !== 4'd1) begin errors++; $display("FAIL place_count: got %0d exp 1", ship_count); end
        read_cell(8'h23, v);
        checks++; if (v !== 2'b01) begin errors++; $display("FAIL place_cell_23: got %b exp 01", v); end
        read_cell(8'h45, v);
        checks++; if (v !== 2'b00) begin errors++; $display("FAIL place_disabled_45: got %b exp 00", v); end
        read_cell(8'hA0, v);
        checks++; if (v !== 2'b00) begin errors++; $display("FAIL place_oob_read: got %b exp 00", v); end
    endtask

    task automatic test_saturation();
        logic [7:0] used [$];
        logic [7:0] a;
        logic [1:0] v;
        reset_dut();
        while (used.size() < 12) begin
            a = {4'($urandom_range(0, GRID_N - 1)), 4'($urandom_range(0, GRID_N - 1))};
            if (a inside {used}) continue;
            used.push_back(a);
            do_pick(a, 1'b1);
            checks++; if (ship_count !== 4'(m_ships)) begin errors++; $display("FAIL sat_count[%0d]: got %0d exp %0d", used.size(), ship_count, m_ships); end
        end
        checks++; if (ship_count !== 4'd11) begin errors++; $display("FAIL sat_final: got %0d exp 11", ship_count); end
        read_cell(used[11], v);
        checks++; if (v !== 2'b00) begin errors++; $display("FAIL sat_12th_cell: got %b exp 00", v); end
        read_cell(used[10], v);
        checks++; if (v !== 2'b01) begin errors++; $display("FAIL sat_11th_cell: got %b exp 01", v); end
    endtask

    task automatic test_shots();
        logic [7:0] shots [4] = '{8'h55, 8'h00, 8'h00, 8'h01};
        logic [1:0] want [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
        logic [1:0] msg, exp_msg, v;
        int lat;
        reset_dut();
        do_pick(8'h00, 1'b1);
        do_pick(8'h01, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp_msg = model_shot(shots[i]);
            do_shot(shots[i], msg, lat);
            checks++; if (lat != 3) begin errors++; $display("FAIL shot_latency[%0d]: got %0d exp 3", i, lat); end
            checks++; if (msg !== exp_msg || msg !== want[i]) begin errors++; $display("FAIL shot_msg[%0d]: got %b exp %b", i, msg, want[i]); end
        end
        checks++; if (bus.fleet_lost !== 1'b1) begin errors++; $display("FAIL shot_fleet_lost: got %b exp 1", bus.fleet_lost); end
        read_cell(8'h55, v);
        checks++; if (v !== 2'b11) begin errors++; $display("FAIL shot_miss_cell: got %b exp 11", v); end
        read_cell(8'h00, v);
        checks++; if (v !== 2'b10) begin errors++; $display("FAIL shot_hit_cell: got %b exp 10", v); end
    endtask

    task automatic test_handshake();
        logic [1:0] v;
        int lat;
        reset_dut();
        do_pick(8'h33, 1'b1);
        @(negedge clk);
        bus.shot_valid = 1'b1; bus.shot_addr = 8'h77;
        @(negedge clk);
        bus.shot_valid = 1'b0;
        lat = 1;
        while (!bus.msg_valid && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat != 3) begin errors++; $display("FAIL hs_latency: got %0d exp 3", lat); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.msg_valid !== 1'b1 || bus.msg_out !== 2'b01 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL hs_hold[%0d]: got valid=%b out=%b busy=%b exp 1/01/1", i, bus.msg_valid, bus.msg_out, bus.busy);
            end
            bus.shot_valid = (i == 2); bus.shot_addr = 8'h33;
            @(negedge clk);
        end
        bus.shot_valid = 1'b0;
        bus.msg_ready = 1'b1;
        @(negedge clk);
        bus.msg_ready = 1'b0;
        checks++; if (bus.msg_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL hs_release: got valid=%b busy=%b exp 0/0", bus.msg_valid, bus.busy); end
        lat = 0;
        repeat (6) begin @(negedge clk); if (bus.msg_valid || bus.busy) lat++; end
        checks++; if (lat != 0) begin errors++; $display("FAIL hs_dropped_shot: got %0d active cycles exp 0", lat); end
        read_cell(8'h33, v);
        checks++; if (v !== 2'b01) begin errors++; $display("FAIL hs_dropped_cell: got %b exp 01", v); end
    endtask

    task automatic test_priority();
        logic [1:0] exp_msg;
        int lat;
        reset_dut();
        do_pick(8'h11, 1'b1);
        exp_msg = model_shot(8'h99);
        @(negedge clk);
        pick_ship = 1'b1; mouse_position = 8'h22;
        bus.shot_valid = 1'b1; bus.shot_addr = 8'h99;
        @(negedge clk);
        pick_ship = 1'b0; bus.shot_valid = 1'b0;
        lat = 1;
        while (!bus.msg_valid && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat != 3 || bus.msg_out !== exp_msg) begin errors++; $display("FAIL prio_msg: got lat=%0d out=%b exp 3/%b", lat, bus.msg_out, exp_msg); end
        checks++; if (ship_count !== 4'd1) begin errors++; $display("FAIL prio_count_busy: got %0d exp 1", ship_count); end
        bus.msg_ready = 1'b1;
        @(negedge clk);
        bus.msg_ready = 1'b0;
        checks++; if (ship_count !== 4'd1) begin errors++; $display("FAIL prio_count_idle: got %0d exp 1", ship_count); end
        @(negedge clk);
        model_place(8'h22, 1'b1);
        checks++; if (ship_count !== 4'(m_ships)) begin errors++; $display("FAIL prio_commit: got %0d exp %0d", ship_count, m_ships); end
    endtask

    task automatic test_random();
        logic [7:0] placed [$];
        logic [7:0] a;
        logic [1:0] msg, exp_msg, v;
        int lat;
        bit en;
        reset_dut();
        for (int i = 0; i < 60; i++) begin
            a = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
            if ($urandom_range(0, 1) == 0) begin
                en = ($urandom_range(0, 3) != 0);
                do_pick(a, en);
                placed.push_back(a);
                checks++; if (ship_count !== 4'(m_ships)) begin errors++; $display("FAIL rnd_count[%0d]: got %0d exp %0d", i, ship_count, m_ships); end
            end else begin
                if (placed.size() > 0 && $urandom_range(0, 1) == 0) a = placed[$urandom_range(0, placed.size() - 1)];
                exp_msg = model_shot(a);
                do_shot(a, msg, lat);
                checks++; if (lat != 3 || msg !== exp_msg) begin errors++; $display("FAIL rnd_shot[%0d] addr=%h: got lat=%0d msg=%b exp 3/%b", i, a, lat, msg, exp_msg); end
                checks++; if (bus.fleet_lost !== m_lost) begin errors++; $display("FAIL rnd_lost[%0d]: got %b exp %b", i, bus.fleet_lost, m_lost); end
            end
        end
        lat = 0;
        for (int r = 0; r < GRID_N; r++)
            for (int c = 0; c < GRID_N; c++) begin
                read_cell({4'(r), 4'(c)}, v);
                if (v !== 2'(grid[r][c])) lat++;
            end
        checks++; if (lat != 0) begin errors++; $display("FAIL rnd_board_scan: got %0d wrong cells exp 0", lat); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] msg, exp_msg, v;
        int lat;
        reset_dut();
        do_pick(8'h44, 1'b1);
        @(negedge clk);
        bus.shot_valid = 1'b1; bus.shot_addr = 8'h44;
        @(negedge clk);
        bus.shot_valid = 1'b0;
        lat = 1;
        while (!bus.msg_valid && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat != 3 || bus.fleet_lost !== 1'b1) begin errors++; $display("FAIL mid_pre: got lat=%0d lost=%b exp 3/1", lat, bus.fleet_lost); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.msg_valid !== 1'b0 || bus.busy !== 1'b0 || ship_count !== 4'd0 || bus.fleet_lost !== 1'b0 || rd_cell !== 2'b00) begin
            errors++;
            $display("FAIL mid_async_rst: got valid=%b busy=%b cnt=%0d lost=%b rd=%b exp 0/0/0/0/00",
                     bus.msg_valid, bus.busy, ship_count, bus.fleet_lost, rd_cell);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        read_cell(8'h44, v);
        checks++; if (v !== 2'b00) begin errors++; $display("FAIL mid_rst_cell: got %b exp 00", v); end
        do_pick(8'h11, 1'b1);
        @(negedge clk);
        bus.shot_valid = 1'b1; bus.shot_addr = 8'h11;
        @(negedge clk);
        bus.shot_valid = 1'b0; board_clr = 1'b1;
        @(negedge clk);
        board_clr = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || ship_count !== 4'd0 || bus.msg_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_clr: got busy=%b cnt=%0d valid=%b exp 0/0/0", bus.busy, ship_count, bus.msg_valid);
        end
        lat = 0;
        repeat (5) begin @(negedge clk); if (bus.msg_valid) lat++; end
        checks++; if (lat != 0) begin errors++; $display("FAIL mid_clr_quiet: got %0d valid cycles exp 0", lat); end
        model_clear();
        exp_msg = model_shot(8'h11);
        do_shot(8'h11, msg, lat);
        checks++; if (lat != 3 || msg !== exp_msg) begin errors++; $display("FAIL mid_clr_shot: got lat=%0d msg=%b exp 3/%b", lat, msg, exp_msg); end
    endtask

    initial begin
        test_reset();
        test_placement();
        test_saturation();
        test_shots();
        test_handshake();
        test_priority();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ship_board.md
Name: ship_board

Overview:
- Own-fleet board store for the battleship game: a 10x10 grid, 2 bits per cell.
- Placement phase: commits ship cells selected by the game-control FSM (pick_ship edge plus latched mouse_position cell) and reports ship_count back to it.
- Game phase: resolves opponent shot addresses (addres4check from the link receiver) against the grid and returns a hit/miss/fleet-sunk message for the transmitter.
- Also provides a 1-cycle-latency read port for the board renderer.

Parameters:
GRID_N, 10, rows/columns per board; coordinates outside 0..GRID_N-1 are invalid
MAX_SHIPS, 11, maximum ship cells placed; ship_count saturates here

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
board_clr  in  1  synchronous clear of grid, counters, FSM (new game)
place_en  in  1  high while game control is in PICK_SHIP
pick_ship  in  1  level request; rising edge = place one cell
mouse_position  in  8  [7:4] row, [3:0] col of the cursor cell
ship_count  out  4  ship cells placed, 0..MAX_SHIPS
shot_valid  in  1  1-cycle strobe; shot_addr valid
shot_addr  in  8  [7:4] row, [3:0] col of the incoming shot
busy  out  1  shot FSM not IDLE; shot_valid while busy is dropped
msg_valid  out  1  response valid, held until msg_ready
msg_ready  in  1  transmitter accepts the response
msg_out  out  2  01 miss, 10 hit, 11 hit and fleet sunk
fleet_lost  out  1  sticky; set together with a 11 response
rd_addr  in  8  [7:4] row, [3:0] col for the renderer
rd_cell  out  2  cell state at rd_addr, registered

Behaviour:
- Cell encoding: 00 EMPTY, 01 SHIP, 10 HIT, 11 MISS. Cell index = row*GRID_N + col, 7-bit.
- Reset (rst_n low, asynchronous):
  - all cells EMPTY;
  - ship_count=0, hit counter=0;
  - FSM=IDLE; busy=0, msg_valid=0, msg_out=00, fleet_lost=0, rd_cell=00;
  - pick_ship edge register=0, placement-pending=0.
- board_clr: same effect as reset, but synchronous, on the next clk edge. It overrides all other activity in that cycle.
- Placement:
  - pick_ship is registered; a rising edge with place_en=1 latches mouse_position and sets placement-pending.
  - The pending write commits on the first cycle the shot FSM is IDLE with no shot_valid. Shot activity has priority.
  - Commit only if: row<GRID_N, col<GRID_N, cell EMPTY, and ship_count<MAX_SHIPS. Then cell<=SHIP and ship_count+1. Otherwise it is silently discarded.
  - Pending is cleared in both cases.
  - A new edge while pending overwrites the latched address.
  - With place_en=0, edges are ignored.
- Shot FSM, states IDLE -> LOOKUP -> UPDATE -> RESPOND -> IDLE:
  - IDLE: on shot_valid, latch shot_addr and go to LOOKUP; busy=1 from the next cycle.
  - LOOKUP: read cell into a register. An out-of-range address yields result MISS with no write.
  - UPDATE:
    - SHIP: cell<=HIT, hit counter+1; msg_out=11 if the new hit count equals ship_count (ship_count>0), else 10.
    - EMPTY: cell<=MISS, msg_out=01.
    - HIT: no write, msg_out=10 (repeat shot).
    - MISS: no write, msg_out=01.
  - RESPOND: msg_valid=1 and msg_out stable until the cycle msg_ready=1; then msg_valid=0, busy=0, back to IDLE.
  - Minimum shot-to-msg_valid latency: 3 cycles.
- fleet_lost is set in the UPDATE cycle that produces 11 and stays set until reset or board_clr.
- Shots are resolved regardless of place_en. A shot during placement is valid and is answered normally.
- rd_cell = cell[rd_addr] registered, 1-cycle latency; 00 for out-of-range rd_addr. The write-cycle read returns the old value.
- Counters are 4-bit; arithmetic never wraps (ship_count saturates at MAX_SHIPS).

Decomposition:
- Shared vga_pkg additions:
  - cell-state typedef (EMPTY/SHIP/HIT/MISS);
  - message constants MSG_MISS=2'b01, MSG_HIT=2'b10, MSG_SUNK=2'b11;
  - GRID_N and MAX_SHIPS defaults.
- FSM state typedef stays local to the module.
- One natural sub-module: ship_board_mem, the 100x2-bit register array with one write port, one FSM-lookup read port and one registered render read port, with synchronous clear.

Test Plan:
- Placement: place_en=1, pick_ship pulses at (2,3), (2,3), (10,0) -> ship_count=1; cell (2,3)=01; duplicate and out-of-range are ignored; rd_addr=0x23 gives rd_cell=01 one cycle later.
- Saturation: 12 distinct valid placements -> ship_count stops at 11; 12th cell stays 00.
- Shots: ships at (0,0),(0,1); shot 0x55 -> msg_out=01 (miss), cell=11; shot 0x00 -> 10; shot 0x00 again -> 10 with hit count unchanged; shot 0x01 -> 11, fleet_lost=1.
- Handshake: msg_ready held low 5 cycles -> msg_valid and msg_out stable and busy=1 throughout; shot_valid pulsed meanwhile is dropped; msg_ready=1 -> IDLE next cycle.
- Priority: pick_ship edge in the same cycle as shot_valid -> shot is answered first, then placement commits once IDLE; ship_count increments after msg handshake.
- Reset/clear mid-operation: rst_n low during RESPOND -> msg_valid=0, busy=0, ship_count=0, all cells 00 immediately. board_clr in LOOKUP -> same state on the next edge; a subsequent shot -> 01.
